// File: rtl/kernel_ram_pkg.sv
// Shared defaults and read-owner encoding for the kernel RAM arbiter.
package kernel_ram_pkg;

  localparam int ADDR_W_DEF   = 13;
  localparam int DATA_W_DEF   = 32;
  localparam int STARVE_LIMIT = 16;

  // Which requester the read data arriving next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/kernel_ram_rr_pick.sv
// Two-way round-robin pick with DMA burst lock and CPU starvation override.
module kernel_ram_rr_pick (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic lock,
  input  logic force0,
  output logic gnt0,
  output logic gnt1
);

  logic rr;
  logic last_m1;
  logic lock_active;

  // The lock only counts while m1 still owns the port and is still asking.
  assign lock_active = last_m1 & lock & req1;

  // Resolve this cycle's winner; a lone requester always wins immediately.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (force0)           gnt0 = 1'b1;
      else if (lock_active) gnt1 = 1'b1;
      else if (rr)          gnt1 = 1'b1;
      else                  gnt0 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end
  end

  // Point rr at the loser after each grant, freezing it during a locked burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr      <= 1'b0;
      last_m1 <= 1'b0;
    end else if (gnt0) begin
      rr      <= 1'b1;
      last_m1 <= 1'b0;
    end else if (gnt1) begin
      last_m1 <= 1'b1;
      if (!lock_active) rr <= 1'b0;
    end
  end

endmodule

// File: rtl/kernel_ram_arbiter.sv
// Shares one single-port RAM between the CPU data port (m0) and DMA (m1).
module kernel_ram_arbiter
  import kernel_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic                m0_we,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic                m1_we,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  output logic                ram_write,
  input  logic [DATA_W-1:0]   ram_rdata
);

  logic              pick_gnt0;
  logic              pick_gnt1;
  logic              force0;
  logic [7:0]        starve_cnt;
  logic [ADDR_W-1:0] last_addr;
  owner_e            owner;

  assign force0 = (starve_cnt >= 8'(STARVE_LIMIT));

  kernel_ram_rr_pick u_pick (
    .clk    (clk),
    .reset  (reset),
    .req0   (m0_req),
    .req1   (m1_req),
    .lock   (m1_lock),
    .force0 (force0),
    .gnt0   (pick_gnt0),
    .gnt1   (pick_gnt1)
  );

  // No access may be accepted while reset is held.
  assign m0_gnt = pick_gnt0 & ~reset;
  assign m1_gnt = pick_gnt1 & ~reset;

  // Count consecutive locked m1 grants so the CPU cannot be starved forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (m0_gnt || !m1_lock) begin
      starve_cnt <= 8'd0;
    end else if (m1_gnt && starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Steer the winner onto the RAM port; idle cycles park on the last address.
  always_comb begin
    ram_addr  = last_addr;
    ram_wdata = '0;
    ram_be    = '0;
    ram_write = 1'b0;
    if (m0_gnt) begin
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_be    = m0_be;
      ram_write = m0_we;
    end else if (m1_gnt) begin
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_be    = m1_be;
      ram_write = m1_we;
    end
  end

  // Remember the last granted address and who owns next cycle's read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr <= '0;
      owner     <= OWN_NONE;
    end else begin
      if (m0_gnt || m1_gnt) last_addr <= ram_addr;
      if (m0_gnt && !m0_we)      owner <= OWN_M0;
      else if (m1_gnt && !m1_we) owner <= OWN_M1;
      else                       owner <= OWN_NONE;
    end
  end

  assign m0_rvalid = (owner == OWN_M0);
  assign m1_rvalid = (owner == OWN_M1);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_kernel_ram_arbiter.sv
// Randomised and directed bench for kernel_ram_arbiter with a RAM and reference model.
module tb_kernel_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int VW = 118;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [3:0]    m0_be, m1_be;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [3:0]    ram_be;
  logic          ram_write;
  logic [DW-1:0] ram_rdata = '0;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] shadow  [0:(1<<AW)-1];

  int            m_rr, m_last, m_cnt, m_own;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_last_addr;
  logic          exp_g0, exp_g1, exp_lock_on;
  logic [VW-1:0] exp_vec;

  kernel_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_we(m1_we),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_write(ram_write),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read RAM; read data is left alone on write cycles.
  always @(posedge clk) begin
    if (ram_write) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end else begin
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  function automatic logic [DW-1:0] init_word(input int i);
    logic [15:0] lo;
    lo = 16'(i);
    return {lo ^ 16'h5A5A, ~lo};
  endfunction

  function automatic logic [VW-1:0] get_obs();
    logic any;
    any = m0_gnt | m1_gnt;
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write, ram_addr,
            any ? ram_wdata : 32'h0, any ? ram_be : 4'h0, m0_rdata, m1_rdata};
  endfunction

  task automatic model_reset();
    m_rr = 0; m_last = -1; m_cnt = 0; m_own = -1; m_data = '0; m_last_addr = '0;
  endtask

  // Expected outputs for the current inputs, from the arbitration rules.
  task automatic predict();
    logic          rw, rv0, rv1;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    be;
    exp_g0 = 1'b0; exp_g1 = 1'b0; exp_lock_on = 1'b0;
    if (reset) begin
      exp_vec = '0;
      return;
    end
    exp_lock_on = (m_last == 1) && m1_lock && m1_req;
    if (m0_req && m1_req) begin
      if (m_cnt >= 16)      exp_g0 = 1'b1;
      else if (exp_lock_on) exp_g1 = 1'b1;
      else if (m_rr == 1)   exp_g1 = 1'b1;
      else                  exp_g0 = 1'b1;
    end else begin
      exp_g0 = m0_req;
      exp_g1 = m1_req;
    end
    a = m_last_addr; wd = '0; be = '0; rw = 1'b0;
    if (exp_g0) begin a = m0_addr; wd = m0_wdata; be = m0_be; rw = m0_we; end
    if (exp_g1) begin a = m1_addr; wd = m1_wdata; be = m1_be; rw = m1_we; end
    rv0 = (m_own == 0);
    rv1 = (m_own == 1);
    exp_vec = {exp_g0, exp_g1, rv0, rv1, rw, a, wd, be,
               rv0 ? m_data : 32'h0, rv1 ? m_data : 32'h0};
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic [3:0] b0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [3:0] b1, input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = b0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = b1; m1_lock = lk;
    @(negedge clk);
    predict();
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  // Clock edge: fold the accepted access into the reference model.
  task automatic advance();
    logic          g, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    be;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (exp_g0 || exp_g1) begin
        g  = exp_g1;
        a  = g ? m1_addr : m0_addr;
        we = g ? m1_we : m0_we;
        wd = g ? m1_wdata : m0_wdata;
        be = g ? m1_be : m0_be;
        if (!g) m_rr = 1;
        else if (!exp_lock_on) m_rr = 0;
        m_last = g ? 1 : 0;
        m_last_addr = a;
        if (we) begin
          for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
          m_own = -1;
        end else begin
          m_own = g ? 1 : 0;
          m_data = shadow[a];
        end
      end else begin
        m_own = -1;
      end
      if (exp_g0 || !m1_lock) m_cnt = 0;
      else if (exp_g1 && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 13'h5, 32'h1, 4'hF, 1, 0, 13'h6, 32'h2, 4'hF, 1);
      tests++;
      if (get_obs() !== exp_vec || exp_vec !== '0) begin
        fails++;
        $display("[TB] FAIL reset_hold: got %h want %h", get_obs(), exp_vec);
      end
      advance();
    end
    reset = 1'b0;
    idle();
    tests++;
    if (get_obs() !== exp_vec) begin
      fails++;
      $display("[TB] FAIL reset_release: got %h want %h", get_obs(), exp_vec);
    end
    advance();
  endtask

  task automatic test_single_read();
    drive(1, 0, 13'h010, '0, 4'hF, 0, 0, '0, '0, '0, 0);
    tests++;
    if (get_obs() !== exp_vec || m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_read_gnt: got %h want %h", get_obs(), exp_vec);
    end
    advance();
    idle();
    tests++;
    if (get_obs() !== exp_vec || m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0
        || m0_rdata !== init_word(13'h010)) begin
      fails++;
      $display("[TB] FAIL single_read_data: got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
               m0_rvalid, m0_rdata, init_word(13'h010));
    end
    advance();
  endtask

  task automatic test_alternate();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, AW'(13'h040 + i), '0, 4'hF, 1, 0, AW'(13'h080 + i), '0, 4'hF, 0);
      tests++;
      if (get_obs() !== exp_vec || m0_gnt !== ((i % 2) == 0)
          || (i > 0 && m0_rvalid !== ((i % 2) == 1))) begin
        fails++;
        $display("[TB] FAIL alternate[%0d]: got %h want %h", i, get_obs(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] want;
    want = init_word(13'h020);
    want[15:0] = 16'hBEEF;
    drive(0, 0, '0, '0, '0, 1, 1, 13'h020, 32'hDEADBEEF, 4'b0011, 0);
    tests++;
    if (get_obs() !== exp_vec) begin
      fails++;
      $display("[TB] FAIL byte_write: got %h want %h", get_obs(), exp_vec);
    end
    advance();
    drive(1, 0, 13'h020, '0, 4'hF, 0, 0, '0, '0, '0, 0);
    tests++;
    if (get_obs() !== exp_vec || m1_rvalid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL byte_write_no_rvalid: got %h want %h", get_obs(), exp_vec);
    end
    advance();
    idle();
    tests++;
    if (get_obs() !== exp_vec || m0_rvalid !== 1'b1 || m0_rdata !== want) begin
      fails++;
      $display("[TB] FAIL byte_write_readback: got %h want %h", m0_rdata, want);
    end
    advance();
  endtask

  task automatic test_lock_starvation();
    int   m1_run, first_m0;
    logic after_m1;
    pulse_reset();
    m1_run = 0; first_m0 = -1; after_m1 = 1'b0;
    drive(0, 0, '0, '0, '0, 1, 0, 13'h100, '0, 4'hF, 1);
    tests++;
    if (get_obs() !== exp_vec) begin
      fails++;
      $display("[TB] FAIL lock_start: got %h want %h", get_obs(), exp_vec);
    end
    if (m1_gnt) m1_run = 1;
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, AW'($urandom_range(0, 31)), '0, 4'hF, 1, 0, AW'(13'h100 + i), '0, 4'hF, 1);
      tests++;
      if (get_obs() !== exp_vec) begin
        fails++;
        $display("[TB] FAIL lock_burst[%0d]: got %h want %h", i, get_obs(), exp_vec);
      end
      if (first_m0 >= 0 && i == first_m0 + 1) after_m1 = m1_gnt;
      if (first_m0 < 0) begin
        if (m0_gnt) first_m0 = i;
        else if (m1_gnt) m1_run++;
      end
      advance();
    end
    tests++;
    if (m1_run != 16 || first_m0 < 0 || after_m1 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL starvation_guard: got m1_run=%0d m0_at=%0d m1_after=%b want 16/yes/1",
               m1_run, first_m0, after_m1);
    end
  endtask

  task automatic test_reset_mid_read();
    pulse_reset();
    drive(1, 0, 13'h030, '0, 4'hF, 0, 0, '0, '0, '0, 0);
    tests++;
    if (get_obs() !== exp_vec) begin
      fails++;
      $display("[TB] FAIL mid_read_grant: got %h want %h", get_obs(), exp_vec);
    end
    advance();
    reset = 1'b1;
    drive(1, 0, 13'h031, '0, 4'hF, 1, 0, 13'h032, '0, 4'hF, 0);
    tests++;
    if (get_obs() !== exp_vec || m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_read_reset: got %h want %h", get_obs(), exp_vec);
    end
    advance();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      tests++;
      if (get_obs() !== exp_vec || get_obs() !== '0) begin
        fails++;
        $display("[TB] FAIL post_reset_idle[%0d]: got %h want %h", i, get_obs(), exp_vec);
      end
      advance();
    end
    drive(0, 0, '0, '0, '0, 1, 0, 13'h033, '0, 4'hF, 0);
    tests++;
    if (get_obs() !== exp_vec || m1_gnt !== 1'b1) begin
      fails++;
      $display("[TB] FAIL post_reset_first: got %h want %h", get_obs(), exp_vec);
    end
    advance();
  endtask

  task automatic test_random();
    logic lk;
    lk = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) lk = ~lk;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)), lk);
      tests++;
      if (get_obs() !== exp_vec) begin
        fails++;
        $display("[TB] FAIL random[%0d]: got %h want %h", i, get_obs(), exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = init_word(i);
      shadow[i]  = init_word(i);
    end
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0; m1_lock = 0;
    model_reset();
    #1;
    test_reset();
    test_single_read();
    test_alternate();
    test_byte_write();
    test_lock_starvation();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kernel_ram_arbiter.md
KERNEL_RAM_ARBITER -- requirements
Module: kernel_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: word-address width of the shared RAM data port.
REQ-002 Parameter DATA_W, default 32: data width; byte-enable width is DATA_W/8.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mN_req  in  1  requester N (N=0 CPU data, N=1 DMA) wants one access this cycle.
REQ-006 mN_addr  in  ADDR_W  word address; mN_wdata  in  DATA_W  write data; mN_be  in  DATA_W/8  byte enables; mN_we  in  1  1=write, 0=read.
REQ-007 m1_lock  in  1  DMA burst lock: while high and m1 owns the port, m1 keeps priority.
REQ-008 mN_gnt  out  1  access accepted this cycle (combinational from inputs and state).
REQ-009 mN_rvalid  out  1  read data valid; mN_rdata  out  DATA_W  read data.
REQ-010 ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_be  out  DATA_W/8; ram_write  out  1; ram_rdata  in  DATA_W (one-cycle registered read, not updated on write cycles).

Function
REQ-011 At most one mN_gnt SHALL be high per cycle; gnt SHALL be high only when the matching mN_req is high.
REQ-012 Single requester: grant it in the same cycle, no bubble.
REQ-013 Both requesting: grant the requester indicated by round-robin pointer rr (0 or 1); after each grant rr SHALL point to the non-granted requester.
REQ-014 Lock: if the previous grant went to m1 and m1_lock is high, m1 SHALL win any conflict and rr SHALL not advance; m1_lock SHALL be ignored when m1_req is low.
REQ-015 Starvation guard: an 8-bit counter of consecutive locked m1 grants SHALL force one m0 grant when it reaches 16 while m0_req is high, then clear; counter clears on any m0 grant or m1_lock low.
REQ-016 ram_* SHALL mirror the granted requester's addr/wdata/be/we; ram_write SHALL be 0 when no grant; idle ram_addr SHALL hold the last granted address.
REQ-017 Granted read: owner register SHALL record requester; next cycle mN_rvalid=1 for that requester only, mN_rdata=ram_rdata; other requester's rvalid=0.
REQ-018 Writes SHALL produce no rvalid.
REQ-019 Back-to-back reads from alternating requesters SHALL each return in the cycle after their grant, full throughput (one access per cycle).
REQ-020 mN_rdata SHALL equal ram_rdata when rvalid is high; value undefined otherwise is not allowed: drive 0 when rvalid low.
REQ-021 Write followed by read of the same address in the next cycle SHALL return the new data (RAM ordering; arbiter adds no reordering).

Reset
REQ-022 During reset: both gnt=0, both rvalid=0, rdata=0, ram_write=0, ram_addr=0, rr=0 (m0 favoured), owner=none, lock counter=0.
REQ-023 A read granted in the cycle reset asserts SHALL yield no rvalid after reset deasserts.
REQ-024 First cycle after reset release SHALL arbitrate normally.

Structure
REQ-025 ADDR_W/DATA_W defaults and the owner encoding (NONE, M0, M1) SHALL live in shared package kernel_ram_pkg.
REQ-026 The two-way round-robin pick with lock SHALL be sub-module kernel_ram_rr_pick; muxing, owner and starvation counter stay in the top module.

Verification
REQ-027 m0 read addr 0x010 alone -> m0_gnt same cycle, m0_rvalid next cycle with mem[0x010], m1_rvalid=0.
REQ-028 Both request every cycle after reset -> grants alternate m0,m1,m0,m1; each rvalid one cycle after its grant.
REQ-029 m1 write 0xDEADBEEF be=4'b0011 to 0x020, then m0 read 0x020 -> m0_rdata low half 0xBEEF, upper half unchanged.
REQ-030 m1_lock high, both requesting continuously -> 16 consecutive m1 grants, then one m0 grant, then m1 resumes.
REQ-031 Assert reset the cycle after an m0 read grant -> m0_rvalid stays 0; after release all outputs at reset values until a request.
